usb_output: RTL

- Transmit side of the FTDI FT245-style USB FIFO link, the counterpart of usb_input.
- Accepts bytes from on-chip logic (for example, flash readback during a dump to the PC) through a small internal FIFO.
- Drains that FIFO to the FTDI chip using the TXE#/WR handshake.
- Runs on the 27 MHz system clock.

---
 rtl/usb_output_if.sv | 27 ++
 rtl/usb_output.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/usb_output_if.sv
// Byte-push side and FTDI FT245 transmit pins of usb_output, bundled for port hookup.
// master = on-chip producer/board model, slave = usb_output.
`timescale 1ns/1ps
interface usb_output_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          indata;
  logic                inwrite;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic [7:0]          data;
  logic                data_oe;
  logic                txe;
  logic                wr;

  modport master (
    output indata, inwrite, txe,
    input  full, empty, count, overflow, data, data_oe, wr
  );

  modport slave (
    input  indata, inwrite, txe,
    output full, empty, count, overflow, data, data_oe, wr
  );
endinterface

// File: rtl/usb_output.sv
// FT245 transmit: byte FIFO drained over TXE#/WR, 8 clocks per byte with defaults.
// No backpressure on pushes: a push while full is dropped and flags sticky overflow.
`timescale 1ns/1ps
module usb_output #(
  parameter int DEPTH_LOG2     = 4,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset_b,
  usb_output_if.slave bus,
  output logic [15:0] bytes_sent,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SETUP   = 4'd1,
    S_STROBE  = 4'd2,
    S_HOLD    = 4'd3,
    S_RECOVER = 4'd4
  } state_e;

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [7:0]          WR_LOAD   = 8'(WR_HIGH_CYCLES - 1);
  localparam logic [7:0]          HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]          REC_LOAD  = 8'(RECOVER_CYCLES - 1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  txe_meta_q, txe_s_q;
  state_e                state_q, state_d;
  logic [7:0]            timer_q, timer_d;
  logic [7:0]            data_q, data_d;
  logic                  data_oe_q, data_oe_d;
  logic                  wr_q, wr_d;
  logic [15:0]           bytes_sent_q, bytes_sent_d;
  logic                  full_w, empty_w, push, pop;

  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);
  assign push    = bus.inwrite && !full_w;
  // txe is only consulted from IDLE; a late TXE# rise never aborts a byte.
  assign pop     = (state_q == S_IDLE) && !empty_w && !txe_s_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.inwrite & full_w);
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    data_d       = data_q;
    data_oe_d    = data_oe_q;
    wr_d         = wr_q;
    bytes_sent_d = bytes_sent_q;
    case (state_q)
      S_IDLE: begin
        wr_d      = 1'b0;
        data_oe_d = 1'b0;
        if (pop) begin
          data_d    = mem_q[rptr_q];
          data_oe_d = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        wr_d    = 1'b1;
        timer_d = WR_LOAD;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (timer_q == '0) begin
          wr_d    = 1'b0;
          timer_d = HOLD_LOAD;
          state_d = S_HOLD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (timer_q == '0) begin
          data_oe_d    = 1'b0;
          bytes_sent_d = bytes_sent_q + 1'b1;
          timer_d      = REC_LOAD;
          state_d      = S_RECOVER;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_RECOVER: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: begin
        wr_d      = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= bus.indata;
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      txe_meta_q   <= 1'b1;
      txe_s_q      <= 1'b1;
      state_q      <= S_IDLE;
      timer_q      <= '0;
      data_q       <= '0;
      data_oe_q    <= 1'b0;
      wr_q         <= 1'b0;
      bytes_sent_q <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      txe_meta_q   <= bus.txe;
      txe_s_q      <= txe_meta_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      data_q       <= data_d;
      data_oe_q    <= data_oe_d;
      wr_q         <= wr_d;
      bytes_sent_q <= bytes_sent_d;
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.data     = data_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.wr       = wr_q;
  assign bytes_sent   = bytes_sent_q;
  assign state        = state_q;
endmodule
